// File: rtl/klein_seq_control_if.sv
// Handshake and select bundle between the KLEIN core wrapper and the round/step sequencer.
// The master side drives start/en/key_mode; the slave (sequencer) drives status and selects.
interface klein_seq_control_if #(
    parameter int RW = 5
);
    logic          start;
    logic          en;
    logic [1:0]    key_mode;
    logic          busy;
    logic [RW-1:0] round;
    logic [2:0]    step;
    logic          round0;
    logic          last_round;
    logic          fin;
    logic [3:0]    sels;
    logic [3:0]    selk;
    logic          ready;

    modport master (
        output start, en, key_mode,
        input  busy, round, step, round0, last_round, fin, sels, selk, ready
    );

    modport slave (
        input  start, en, key_mode,
        output busy, round, step, round0, last_round, fin, sels, selk, ready
    );
endinterface

// File: rtl/klein_seq_control.sv
// Round/step sequencer for the serialised KLEIN datapath (KLEIN-64/80/96).
// Eight steps per round, one final whitening cycle, one ready cycle; start restarts at any time.
module klein_seq_control #(
    parameter int NR64 = 12,
    parameter int NR80 = 16,
    parameter int NR96 = 20,
    parameter int RW   = 5
) (
    input  logic                ck,
    input  logic                rst,
    klein_seq_control_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [RW-1:0] NR64_W = RW'(NR64);
    localparam logic [RW-1:0] NR80_W = RW'(NR80);
    localparam logic [RW-1:0] NR96_W = RW'(NR96);
    localparam logic [RW-1:0] ONE_W  = RW'(1);

    state_t        state_q, state_d;
    logic [RW-1:0] round_q, round_d;
    logic [2:0]    step_q, step_d;
    logic [1:0]    mode_q, mode_d;

    logic [RW-1:0] nr_s;
    logic [RW-1:0] nr_m1_s;
    logic          busy_s, round0_s, last_round_s, fin_s, ready_s;
    logic [3:0]    sels_s, selk_s;

    // Round count of the run in progress, taken from the mode latched at start
    always_comb begin
        case (mode_q)
            2'd1:    nr_s = NR80_W;
            2'd2:    nr_s = NR96_W;
            default: nr_s = NR64_W;
        endcase
        nr_m1_s = nr_s - ONE_W;
    end

    // Sequencer state register with synchronous reset
    always_ff @(posedge ck) begin
        if (rst) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            step_q  <= 3'd0;
            mode_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            step_q  <= step_d;
            mode_q  <= mode_d;
        end
    end

    // Next-state logic; start overrides everything, including a stall
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        step_d  = step_q;
        mode_d  = mode_q;
        if (bus.start) begin
            state_d = ST_RUN;
            round_d = '0;
            step_d  = 3'd0;
            mode_d  = bus.key_mode;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.en) begin
                        step_d = step_q + 3'd1;
                        if (step_q == 3'd7) begin
                            round_d = round_q + ONE_W;
                            if (round_q == nr_m1_s) begin
                                state_d = ST_FINAL;
                            end else begin
                                state_d = ST_RUN;
                            end
                        end else begin
                            round_d = round_q;
                        end
                    end else begin
                        step_d = step_q;
                    end
                end
                ST_FINAL: state_d = ST_DONE;
                ST_DONE:  state_d = ST_IDLE;
                ST_IDLE:  step_d  = 3'd0;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Output decode of the registered state; selects are zero unless RUN advances
    always_comb begin
        busy_s       = 1'b0;
        last_round_s = 1'b0;
        fin_s        = 1'b0;
        ready_s      = 1'b0;
        sels_s       = 4'b0000;
        selk_s       = 4'b0000;
        case (state_q)
            ST_RUN: begin
                busy_s       = 1'b1;
                last_round_s = (round_q == nr_m1_s);
                if (bus.en) begin
                    case (step_q)
                        3'd0:    begin sels_s = 4'b0111; selk_s = 4'b0000; end
                        3'd1:    begin sels_s = 4'b1011; selk_s = 4'b0000; end
                        3'd2:    begin sels_s = 4'b1001; selk_s = 4'b0010; end
                        3'd3:    begin sels_s = 4'b0000; selk_s = 4'b0101; end
                        3'd4:    begin sels_s = 4'b0111; selk_s = 4'b1001; end
                        3'd5:    begin sels_s = 4'b0011; selk_s = 4'b1000; end
                        3'd6:    begin sels_s = 4'b0001; selk_s = 4'b1000; end
                        3'd7:    begin sels_s = 4'b0000; selk_s = 4'b1100; end
                        default: begin sels_s = 4'b0000; selk_s = 4'b0000; end
                    endcase
                end else begin
                    sels_s = 4'b0000;
                    selk_s = 4'b0000;
                end
            end
            ST_FINAL: begin
                busy_s = 1'b1;
                fin_s  = 1'b1;
            end
            ST_DONE: ready_s = 1'b1;
            default: busy_s  = 1'b0;
        endcase
        round0_s = busy_s & (round_q == '0);
    end

    assign bus.busy       = busy_s;
    assign bus.round      = round_q;
    assign bus.step       = step_q;
    assign bus.round0     = round0_s;
    assign bus.last_round = last_round_s;
    assign bus.fin        = fin_s;
    assign bus.sels       = sels_s;
    assign bus.selk       = selk_s;
    assign bus.ready      = ready_s;
endmodule

// File: tb/tb_klein_seq_control.sv
// Scoreboard bench for klein_seq_control: a run-position model predicts every cycle's outputs.
module tb_klein_seq_control;
    localparam int RW = 5;

    typedef struct packed {
        logic          busy;
        logic [RW-1:0] round;
        logic [2:0]    step;
        logic          round0;
        logic          last_round;
        logic          fin;
        logic [3:0]    sels;
        logic [3:0]    selk;
        logic          ready;
    } obs_t;

    logic ck;
    logic rst;
    obs_t scb[$];
    obs_t e_obs, g_obs;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc_no   = 0;

    // Model: m_pos = -1 when idle, otherwise cycles advanced since start.
    int m_pos  = -1;
    int m_nr   = 12;
    int m_hold = 0;

    logic [3:0] sels_tbl [8];
    logic [3:0] selk_tbl [8];

    klein_seq_control_if #(.RW(RW)) bus ();

    klein_seq_control #(.NR64(12), .NR80(16), .NR96(20), .RW(RW)) dut (
        .ck  (ck),
        .rst (rst),
        .bus (bus.slave)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    function automatic int nr_of(input logic [1:0] m);
        if (m == 2'd1) return 16;
        else if (m == 2'd2) return 20;
        else return 12;
    endfunction

    function automatic obs_t predict(input logic en_v);
        obs_t o;
        o = '0;
        if (m_pos < 0) begin
            o.round = RW'(m_hold);
        end else if (m_pos < 8 * m_nr) begin
            o.busy       = 1'b1;
            o.round      = RW'(m_pos / 8);
            o.step       = 3'(m_pos % 8);
            o.round0     = (m_pos < 8);
            o.last_round = ((m_pos / 8) == m_nr - 1);
            if (en_v) begin
                o.sels = sels_tbl[m_pos % 8];
                o.selk = selk_tbl[m_pos % 8];
            end
        end else if (m_pos == 8 * m_nr) begin
            o.busy  = 1'b1;
            o.round = RW'(m_nr);
            o.fin   = 1'b1;
        end else begin
            o.round = RW'(m_nr);
            o.ready = 1'b1;
        end
        return o;
    endfunction

    task automatic model_update(input logic r, input logic s, input logic en_v, input logic [1:0] m);
        if (r) begin
            m_pos  = -1;
            m_hold = 0;
        end else if (s) begin
            m_pos = 0;
            m_nr  = nr_of(m);
        end else if (m_pos < 0) begin
            m_pos = -1;
        end else if (m_pos < 8 * m_nr) begin
            if (en_v) m_pos = m_pos + 1;
        end else if (m_pos == 8 * m_nr) begin
            m_pos = m_pos + 1;
        end else begin
            m_hold = m_nr;
            m_pos  = -1;
        end
    endtask

    // Drive one cycle: inputs set shortly after the edge, prediction queued, model advanced at the edge.
    task automatic cyc(input logic r, input logic s, input logic en_v, input logic [1:0] m);
        rst          = r;
        bus.start    = s;
        bus.en       = en_v;
        bus.key_mode = m;
        scb.push_back(predict(en_v));
        @(posedge ck);
        model_update(r, s, en_v, m);
        #2;
    endtask

    task automatic run_en(input int n, input logic [1:0] m);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, m);
    endtask

    // Directed reset-state check: every output must be zero.
    task automatic check_idle(input string tag);
        n_checks = n_checks + 1;
        if (bus.busy === 1'b0 && bus.round === '0 && bus.step === 3'd0 &&
            bus.round0 === 1'b0 && bus.last_round === 1'b0 && bus.fin === 1'b0 &&
            bus.sels === 4'b0000 && bus.selk === 4'b0000 && bus.ready === 1'b0) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s t=%0t got busy=%b round=%0d step=%0d r0=%b last=%b fin=%b sels=%b selk=%b ready=%b ; required all zero",
                     tag, $time, bus.busy, bus.round, bus.step, bus.round0, bus.last_round,
                     bus.fin, bus.sels, bus.selk, bus.ready);
        end
    endtask

    // Monitor: compare DUT outputs against the queued prediction mid-cycle.
    always @(negedge ck) begin
        cyc_no = cyc_no + 1;
        if (scb.size() != 0) begin
            e_obs = scb.pop_front();
            g_obs = {bus.busy, bus.round, bus.step, bus.round0, bus.last_round,
                     bus.fin, bus.sels, bus.selk, bus.ready};
            n_checks = n_checks + 1;
            if (g_obs === e_obs) begin
                n_pass = n_pass + 1;
            end else begin
                $display("FAIL outputs t=%0t got busy=%b round=%0d step=%0d r0=%b last=%b fin=%b sels=%b selk=%b ready=%b ; required busy=%b round=%0d step=%0d r0=%b last=%b fin=%b sels=%b selk=%b ready=%b",
                         $time, g_obs.busy, g_obs.round, g_obs.step, g_obs.round0, g_obs.last_round,
                         g_obs.fin, g_obs.sels, g_obs.selk, g_obs.ready,
                         e_obs.busy, e_obs.round, e_obs.step, e_obs.round0, e_obs.last_round,
                         e_obs.fin, e_obs.sels, e_obs.selk, e_obs.ready);
            end
        end
    end

    initial begin
        int ready_at;
        sels_tbl[0] = 4'b0111; selk_tbl[0] = 4'b0000;
        sels_tbl[1] = 4'b1011; selk_tbl[1] = 4'b0000;
        sels_tbl[2] = 4'b1001; selk_tbl[2] = 4'b0010;
        sels_tbl[3] = 4'b0000; selk_tbl[3] = 4'b0101;
        sels_tbl[4] = 4'b0111; selk_tbl[4] = 4'b1001;
        sels_tbl[5] = 4'b0011; selk_tbl[5] = 4'b1000;
        sels_tbl[6] = 4'b0001; selk_tbl[6] = 4'b1000;
        sels_tbl[7] = 4'b0000; selk_tbl[7] = 4'b1100;

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.en       = 1'b0;
        bus.key_mode = 2'd0;
        @(posedge ck);
        @(posedge ck);
        #2;

        // Reset held, then idle.
        cyc(1'b1, 1'b0, 1'b0, 2'd0);
        check_idle("reset-state");
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 2'd0);
        check_idle("idle-after-reset");

        // Full runs in every key mode, en high; the first waits for ready with a timeout.
        cyc(1'b0, 1'b1, 1'b1, 2'd0);
        ready_at = -1;
        for (int i = 0; i < 102; i++) begin
            if (ready_at < 0 && bus.ready === 1'b1) ready_at = i;
            cyc(1'b0, 1'b0, 1'b1, 2'd0);
        end
        n_checks = n_checks + 1;
        if (ready_at < 0) begin
            $display("FAIL wait for ready expired after 102 cycles t=%0t", $time);
        end else if (ready_at != 97) begin
            $display("FAIL ready at cycle %0d, required cycle 98", ready_at + 1);
        end else begin
            n_pass = n_pass + 1;
        end
        cyc(1'b0, 1'b1, 1'b1, 2'd1); run_en(134, 2'd1);
        cyc(1'b0, 1'b1, 1'b1, 2'd2); run_en(166, 2'd2);
        cyc(1'b0, 1'b1, 1'b1, 2'd3); run_en(102, 2'd3);

        // Three-cycle stall at round 4 step 5.
        cyc(1'b0, 1'b1, 1'b1, 2'd0);
        run_en(37, 2'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 2'd0);
        run_en(65, 2'd0);

        // Restart at round 7 step 3, then let the new run complete.
        cyc(1'b0, 1'b1, 1'b1, 2'd0);
        run_en(59, 2'd0);
        cyc(1'b0, 1'b1, 1'b1, 2'd0);
        run_en(102, 2'd0);

        // Reset with a simultaneous start at round 5.
        cyc(1'b0, 1'b1, 1'b1, 2'd0);
        run_en(40, 2'd0);
        cyc(1'b1, 1'b1, 1'b1, 2'd0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 2'd0);

        // Start in the DONE cycle; key_mode wiggles mid-run without effect.
        cyc(1'b0, 1'b1, 1'b1, 2'd0);
        run_en(97, 2'd0);
        cyc(1'b0, 1'b1, 1'b1, 2'd2);
        for (int i = 0; i < 170; i++) cyc(1'b0, 1'b0, 1'b1, 2'($urandom_range(0, 3)));

        // Start in the FINAL cycle.
        cyc(1'b0, 1'b1, 1'b1, 2'd0);
        run_en(96, 2'd0);
        cyc(1'b0, 1'b1, 1'b0, 2'd1);
        run_en(136, 2'd0);

        // Randomised runs with stalls, restarts and rare resets.
        for (int r = 0; r < 25; r++) begin
            int len;
            cyc(1'b0, 1'b1, 1'b1, 2'($urandom_range(0, 3)));
            len = $urandom_range(20, 260);
            for (int k = 0; k < len; k++) begin
                cyc(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 199) == 0),
                    1'($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)));
            end
        end

        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 2'd0);
        @(negedge ck);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
